// File: rtl/nvdla_cmac_reg_master_if.sv
// nvdla_cmac_reg_master_if: CSB request, flat register and response signals; master = initiator side, slave = fabric/responder side
interface nvdla_cmac_reg_master_if;
  logic        req_pvld;
  logic        req_prdy;
  logic [21:0] req_addr;
  logic [31:0] req_wdat;
  logic        req_write;
  logic        req_nposted;
  logic [11:0] reg_offset;
  logic        reg_wr_en;
  logic [31:0] reg_wr_data;
  logic [31:0] reg_rd_data;
  logic        rsp_valid;
  logic        rsp_is_write;
  logic [31:0] rsp_rdat;
  logic        rsp_error;
  modport master (
    input  req_pvld, req_addr, req_wdat, req_write, req_nposted, reg_rd_data,
    output req_prdy, reg_offset, reg_wr_en, reg_wr_data, rsp_valid, rsp_is_write, rsp_rdat, rsp_error
  );
  modport slave (
    output req_pvld, req_addr, req_wdat, req_write, req_nposted, reg_rd_data,
    input  req_prdy, reg_offset, reg_wr_en, reg_wr_data, rsp_valid, rsp_is_write, rsp_rdat, rsp_error
  );
endinterface

// File: rtl/nvdla_cmac_reg_master.sv
// nvdla_cmac_reg_master: CSB request -> CMAC flat register bus initiator (clk/rst, bus.master request/register/response, err_cnt miss counter)
module nvdla_cmac_reg_master #(
  parameter logic [21:0] BLK_BASE = 22'h1c00
) (
  input  logic                            nvdla_core_clk,
  input  logic                            nvdla_core_rst,
  nvdla_cmac_reg_master_if.master         bus,
  output logic [7:0]                      err_cnt
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t      state_q, state_d;
  logic        hit_q, hit_d;
  logic        write_q, write_d;
  logic        nposted_q, nposted_d;
  logic [11:0] reg_offset_q, reg_offset_d;
  logic        reg_wr_en_q, reg_wr_en_d;
  logic [31:0] reg_wr_data_q, reg_wr_data_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_is_write_q, rsp_is_write_d;
  logic        rsp_error_q, rsp_error_d;
  logic [31:0] rsp_rdat_q, rsp_rdat_d;
  logic [7:0]  err_cnt_q, err_cnt_d;
  logic        accept, req_hit, rsp_live;
  assign bus.req_prdy = (state_q == IDLE || state_q == RESP) && !nvdla_core_rst;
  assign accept       = bus.req_pvld && bus.req_prdy;
  assign req_hit      = bus.req_addr[21:10] == BLK_BASE[21:10];
  assign rsp_live     = rsp_valid_q && !nvdla_core_rst;
  assign bus.reg_offset   = reg_offset_q;
  assign bus.reg_wr_data  = reg_wr_data_q;
  assign bus.reg_wr_en    = reg_wr_en_q && !nvdla_core_rst;
  assign bus.rsp_valid    = rsp_live;
  assign bus.rsp_is_write = rsp_live && rsp_is_write_q;
  assign bus.rsp_error    = rsp_live && rsp_error_q;
  assign bus.rsp_rdat     = rsp_live ? rsp_rdat_q : '0;
  assign err_cnt          = err_cnt_q;
  always_comb begin
    state_d        = accept ? ACCESS : (state_q == ACCESS) ? RESP : IDLE;
    hit_d          = accept ? req_hit : hit_q;
    write_d        = accept ? bus.req_write : write_q;
    nposted_d      = accept ? bus.req_nposted : nposted_q;
    reg_offset_d   = (accept && req_hit) ? {bus.req_addr[9:0], 2'b00} : reg_offset_q;
    reg_wr_data_d  = accept ? bus.req_wdat : reg_wr_data_q;
    reg_wr_en_d    = accept && bus.req_write && req_hit;
    rsp_valid_d    = (state_q == ACCESS) && (!write_q || nposted_q);
    rsp_is_write_d = rsp_valid_d && write_q;
    rsp_error_d    = rsp_valid_d && !hit_q;
    rsp_rdat_d     = (rsp_valid_d && hit_q && !write_q) ? bus.reg_rd_data : '0;
    err_cnt_d      = (state_q == ACCESS && !hit_q && err_cnt_q != 8'hff) ? err_cnt_q + 8'd1 : err_cnt_q;
  end
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      state_q        <= IDLE;
      hit_q          <= 1'b0;
      write_q        <= 1'b0;
      nposted_q      <= 1'b0;
      reg_offset_q   <= '0;
      reg_wr_en_q    <= 1'b0;
      reg_wr_data_q  <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_is_write_q <= 1'b0;
      rsp_error_q    <= 1'b0;
      rsp_rdat_q     <= '0;
      err_cnt_q      <= '0;
    end else begin
      state_q        <= state_d;
      hit_q          <= hit_d;
      write_q        <= write_d;
      nposted_q      <= nposted_d;
      reg_offset_q   <= reg_offset_d;
      reg_wr_en_q    <= reg_wr_en_d;
      reg_wr_data_q  <= reg_wr_data_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_is_write_q <= rsp_is_write_d;
      rsp_error_q    <= rsp_error_d;
      rsp_rdat_q     <= rsp_rdat_d;
      err_cnt_q      <= err_cnt_d;
    end
  end
endmodule

// File: doc/nvdla_cmac_reg_master.md
# nvdla_cmac_reg_master

Register-bus initiator driving the single-register responder of the CMAC register file. It accepts CSB-style requests (address, data, read/write, posted/non-posted) on a valid/ready handshake, decodes whether the word address falls in the CMAC single-register window, and drives the flat register interface `reg_offset` / `reg_wr_en` / `reg_wr_data`. It samples `reg_rd_data` for reads and returns one response per non-posted request. It sits between the CSB fabric and the CMAC register responder.

## Interface
- `BLK_BASE`, default 22'h1c00: word address of the block window; a request hits when `req_addr[21:10] == BLK_BASE[21:10]`.
- `nvdla_core_clk`  in  1  single clock; all logic is on the rising edge.
- `nvdla_core_rst`  in  1  reset; synchronous, active-high.
- `req_pvld`  in  1  request valid.
- `req_prdy`  out  1  request ready.
- `req_addr`  in  22  word address.
- `req_wdat`  in  32  write data.
- `req_write`  in  1  1 = write, 0 = read.
- `req_nposted`  in  1  write needs a response (ignored for reads, which always respond).
- `reg_offset`  out  12  byte offset to responder.
- `reg_wr_en`  out  1  single-cycle write strobe.
- `reg_wr_data`  out  32  write data to responder.
- `reg_rd_data`  in  32  combinational read data for the current `reg_offset`.
- `rsp_valid`  out  1  one-cycle response pulse; no backpressure.
- `rsp_is_write`  out  1  response belongs to a write.
- `rsp_rdat`  out  32  read data; 0 for writes and misses.
- `rsp_error`  out  1  request missed the window.
- `err_cnt`  out  8  saturating count of missed requests.

## Operation
- The FSM has three states: IDLE, ACCESS and RESP. Reset enters IDLE.
- `req_prdy = (state==IDLE || state==RESP) && !nvdla_core_rst`. A request is accepted when `req_pvld && req_prdy`.
- On accept, the block captures addr, wdat, write, nposted and hit into holding registers, then goes to ACCESS.
- ACCESS lasts exactly one cycle:
  - `reg_offset = {addr[9:0], 2'b00}` on a hit.
  - `reg_wr_en = write && hit`.
  - `reg_wr_data = wdat`.
  - For a read hit, `reg_rd_data` is sampled into the response data register. A read miss loads 0.
  - The FSM then goes to RESP.
- RESP:
  - `rsp_valid = 1` if `!write || nposted`. Posted writes produce no pulse.
  - `rsp_is_write = write`, `rsp_error = !hit`, `rsp_rdat` = the sampled data.
  - If a new request is accepted in the same cycle, the FSM goes to ACCESS; otherwise it goes to IDLE.
- On a miss:
  - `reg_wr_en` stays 0 and `reg_offset` holds its previous value, so the responder is never touched.
  - `err_cnt` increments in ACCESS and saturates at 255.
- `reg_offset` and `reg_wr_data` hold their last driven values outside ACCESS. `reg_wr_en` is 0 outside ACCESS.
- `rsp_rdat`, `rsp_is_write` and `rsp_error` are 0 whenever `rsp_valid = 0`.

## Timing
- Reset values: state IDLE, `req_prdy` 0 during reset and 1 the cycle after. `reg_offset` 0, `reg_wr_en` 0, `reg_wr_data` 0, `rsp_valid` 0, `rsp_rdat` 0, `rsp_is_write` 0, `rsp_error` 0, `err_cnt` 0.
- Latency, counted from the accept edge at cycle T:
  - Cycle T+1 is ACCESS: `reg_wr_en` is high, and `reg_rd_data` is sampled at the end of T+1.
  - `rsp_valid` is high in cycle T+2.
- Throughput is one request per 2 cycles: back-to-back accepts land in RESP, so ACCESS and RESP alternate.
- `req_*` inputs are only sampled on the accept edge; changes while `req_prdy = 0` are ignored.
- `reg_rd_data` must be valid in the same cycle `reg_offset` is driven. This is the responder's combinational read mux.
- Reset asserted in ACCESS or RESP:
  - It aborts the request, and any `reg_wr_en` pulse for that cycle is suppressed.
  - No response is produced, and all outputs return to their reset values on the next edge.
- `err_cnt` at 255 stays at 255 on further misses.

## Test plan
- Read hit: accept addr 22'h1c00 with `reg_rd_data` = 32'h0003_0001 -> `reg_offset` 12'h000 at T+1; at T+2 `rsp_valid` = 1, `rsp_rdat` 32'h0003_0001, `rsp_error` 0.
- Non-posted write hit: addr 22'h1c01, wdat 1, nposted 1 -> at T+1 `reg_offset` 12'h004, `reg_wr_en` 1 for exactly one cycle, `reg_wr_data` 1; at T+2 `rsp_valid` 1 with `rsp_is_write` 1.
- Posted write: same write with nposted 0 -> `reg_wr_en` pulse at T+1; `rsp_valid` stays 0.
- Miss: read at addr 22'h0400 -> `reg_wr_en` 0, `reg_offset` unchanged; at T+2 `rsp_error` 1, `rsp_rdat` 0; `err_cnt` goes 0 -> 1. After 300 misses `err_cnt` = 255.
- Back-to-back: `req_pvld` held with 4 reads -> accepts at T, T+2, T+4, T+6; `rsp_valid` pulses at T+2, T+4, T+6, T+8.
- Reset mid-write: assert `nvdla_core_rst` in the accept cycle of a write to 22'h1c01 -> `reg_wr_en` never rises, no `rsp_valid`, and `req_prdy` is 1 the cycle after reset deasserts.
